// File: rtl/ariane_pkg.sv
// Shared core types for the commit path.
// Scoreboard entries, exceptions, FU classes.
package ariane_pkg;

  localparam int unsigned REG_ADDR_SIZE = 5;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR,
    FPU
  } fu_t;

  typedef enum logic [3:0] {
    ADD,
    SUB,
    LD,
    SD,
    FLD,
    FSD,
    FADD,
    CSRRW
  } fu_op_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    fu_t                      fu;
    fu_op_t                   op;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

  function automatic logic is_rd_fpr(input fu_op_t op);
    unique case (op)
      FLD, FADD: is_rd_fpr = 1'b1;
      default:   is_rd_fpr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/commit_stage.sv
// In-order commit of scoreboard head entries.
// Handles stores, exceptions, halt and instret.
module commit_stage
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  input  scoreboard_entry_t commit_instr_i [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0] commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_SIZE-1:0] waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0] wdata_o,
  output logic [NR_COMMIT_PORTS-1:0] we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0] we_fpr_o,
  output logic              commit_lsu_o,
  input  logic              commit_lsu_ready_i,
  output exception_t        exception_o,
  output logic              flush_o,
  output logic [63:0]       instret_o
);

  typedef enum logic [1:0] {
    RUN,
    STORE_WAIT,
    EX_FLUSH,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  exception_t  exception_q, exception_d;
  logic [63:0] instret_q, instret_d;
  logic [NR_COMMIT_PORTS-1:0] ack;

  // Commit FSM: decides which head entries retire this cycle.
  always_comb begin
    state_d      = state_q;
    ack          = '0;
    commit_lsu_o = 1'b0;
    exception_d  = '0;
    unique case (state_q)
      RUN: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (commit_instr_i[0].valid) begin
          if (commit_instr_i[0].ex.valid) begin
            ack[0]      = 1'b1;
            exception_d = commit_instr_i[0].ex;
            state_d     = EX_FLUSH;
          end else if (commit_instr_i[0].fu == STORE) begin
            commit_lsu_o = 1'b1;
            if (commit_lsu_ready_i) ack[0] = 1'b1;
            else state_d = STORE_WAIT;
          end else begin
            ack[0] = 1'b1;
          end
          // Younger ports retire only behind an acked older port.
          for (int n = 1; n < NR_COMMIT_PORTS; n++) begin
            if (ack[n-1] && state_d == RUN &&
                commit_instr_i[n].valid &&
                !commit_instr_i[n].ex.valid &&
                commit_instr_i[n].fu != STORE &&
                commit_instr_i[n].fu != CSR)
              ack[n] = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        commit_lsu_o = 1'b1;
        if (commit_lsu_ready_i && commit_instr_i[0].valid) begin
          ack[0]  = 1'b1;
          state_d = RUN;
        end
      end
      EX_FLUSH: state_d = RUN;
      HALTED: if (!halt_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (rst_i) begin
      state_d      = RUN;
      ack          = '0;
      commit_lsu_o = 1'b0;
      exception_d  = '0;
    end
  end

  // Register-file write ports follow the acks; excepting entries never write.
  always_comb begin
    instret_d = instret_q;
    for (int n = 0; n < NR_COMMIT_PORTS; n++) begin
      waddr_o[n]  = commit_instr_i[n].rd;
      wdata_o[n]  = commit_instr_i[n].result;
      we_fpr_o[n] = ack[n] && !commit_instr_i[n].ex.valid &&
                    is_rd_fpr(commit_instr_i[n].op);
      we_gpr_o[n] = ack[n] && !commit_instr_i[n].ex.valid &&
                    !is_rd_fpr(commit_instr_i[n].op) &&
                    commit_instr_i[n].rd != '0;
      instret_d   = instret_d + {63'd0, ack[n]};
    end
  end

  assign commit_ack_o = ack;
  assign flush_o      = (state_q == EX_FLUSH) && !rst_i;
  assign exception_o  = rst_i ? '0 : exception_q;
  assign instret_o    = instret_q;

  // State, exception report and retired count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      exception_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      exception_q <= exception_d;
      instret_q   <= instret_d;
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage.
// Hand-computed expectations per step.
module tb_commit_stage;
  import ariane_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i, halt_i, lsu_rdy;
  scoreboard_entry_t ci [2];
  logic [1:0] ack, we_gpr, we_fpr;
  logic [1:0][4:0] waddr;
  logic [1:0][63:0] wdata;
  logic lsu, flush;
  exception_t exc;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_ir;

  always #5 clk_i = ~clk_i;

  commit_stage #(.NR_COMMIT_PORTS(2)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .halt_i(halt_i),
    .commit_instr_i(ci),
    .commit_ack_o(ack),
    .waddr_o(waddr),
    .wdata_o(wdata),
    .we_gpr_o(we_gpr),
    .we_fpr_o(we_fpr),
    .commit_lsu_o(lsu),
    .commit_lsu_ready_i(lsu_rdy),
    .exception_o(exc),
    .flush_o(flush),
    .instret_o(instret)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(
      input fu_t f, input fu_op_t o, input logic [4:0] rd,
      input logic [63:0] res, input logic ev, input logic [63:0] cause);
    scoreboard_entry_t e;
    e.fu = f;
    e.op = o;
    e.rd = rd;
    e.result = res;
    e.valid = 1'b1;
    e.ex.cause = ev ? cause : 64'd0;
    e.ex.tval = 64'd0;
    e.ex.valid = ev;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ci[0] = '0;
    ci[1] = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    halt_i = 1'b0;
    lsu_rdy = 1'b0;
    ci[0] = mk(ALU, ADD, 5'd5, 64'h11, 1'b0, 64'd0);
    ci[1] = mk(ALU, ADD, 5'd6, 64'h22, 1'b0, 64'd0);
    #2;
    chk("ack_in_reset", 64'(ack), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    idle();
    #1;
    chk("rst_instret", instret, 64'd0);
    chk("rst_exc_zero", 64'(exc == '0), 64'd1);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_lsu", 64'(lsu), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    exp_ir = 64'd0;

    ci[0] = mk(ALU, ADD, 5'd5, 64'h11, 1'b0, 64'd0);
    ci[1] = mk(ALU, ADD, 5'd6, 64'h22, 1'b0, 64'd0);
    #1;
    chk("dual_ack", 64'(ack), 64'd3);
    chk("dual_gpr", 64'(we_gpr), 64'd3);
    chk("dual_fpr", 64'(we_fpr), 64'd0);
    chk("dual_waddr0", 64'(waddr[0]), 64'd5);
    chk("dual_wdata1", wdata[1], 64'h22);
    tick();
    exp_ir = 64'd2;
    chk("dual_instret", instret, exp_ir);

    ci[0] = mk(ALU, ADD, 5'd0, 64'h99, 1'b0, 64'd0);
    ci[1] = '0;
    #1;
    chk("x0_ack", 64'(ack), 64'd1);
    chk("x0_gpr", 64'(we_gpr), 64'd0);
    tick();
    exp_ir = 64'd3;
    chk("x0_instret", instret, exp_ir);

    ci[0] = mk(LOAD, FLD, 5'd3, 64'h33, 1'b0, 64'd0);
    ci[1] = mk(FPU, FADD, 5'd0, 64'h44, 1'b0, 64'd0);
    #1;
    chk("fp_ack", 64'(ack), 64'd3);
    chk("fp_fpr", 64'(we_fpr), 64'd3);
    chk("fp_gpr", 64'(we_gpr), 64'd0);
    tick();
    exp_ir = 64'd5;

    ci[0] = mk(STORE, SD, 5'd0, 64'h0, 1'b0, 64'd0);
    ci[1] = mk(ALU, ADD, 5'd7, 64'h77, 1'b0, 64'd0);
    lsu_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stw_lsu", 64'(lsu), 64'd1);
      chk("stw_ack", 64'(ack), 64'd0);
      tick();
    end
    lsu_rdy = 1'b1;
    #1;
    chk("stw_lsu4", 64'(lsu), 64'd1);
    chk("stw_ack4", 64'(ack), 64'd1);
    tick();
    exp_ir = 64'd6;
    chk("stw_instret", instret, exp_ir);
    lsu_rdy = 1'b0;
    ci[0] = ci[1];
    ci[1] = '0;
    #1;
    chk("post_st_lsu", 64'(lsu), 64'd0);
    chk("post_st_ack", 64'(ack), 64'd1);
    tick();
    exp_ir = 64'd7;

    ci[0] = mk(STORE, SD, 5'd0, 64'h0, 1'b0, 64'd0);
    ci[1] = mk(ALU, SUB, 5'd9, 64'h5, 1'b0, 64'd0);
    lsu_rdy = 1'b1;
    #1;
    chk("st_fast_lsu", 64'(lsu), 64'd1);
    chk("st_fast_ack", 64'(ack), 64'd3);
    tick();
    exp_ir = 64'd9;
    lsu_rdy = 1'b0;
    chk("st_fast_ir", instret, exp_ir);

    ci[0] = mk(ALU, ADD, 5'd8, 64'h88, 1'b1, 64'd2);
    ci[1] = mk(ALU, ADD, 5'd10, 64'hA, 1'b0, 64'd0);
    #1;
    chk("ex_ack", 64'(ack), 64'd1);
    chk("ex_gpr", 64'(we_gpr), 64'd0);
    chk("ex_flush0", 64'(flush), 64'd0);
    tick();
    exp_ir = 64'd10;
    ci[0] = mk(ALU, ADD, 5'd11, 64'hB, 1'b0, 64'd0);
    #1;
    chk("ex_valid", 64'(exc.valid), 64'd1);
    chk("ex_cause", exc.cause, 64'd2);
    chk("ex_flush", 64'(flush), 64'd1);
    chk("ex_fl_ack", 64'(ack), 64'd0);
    chk("ex_fl_ir", instret, exp_ir);
    tick();
    #1;
    chk("ex_flush_end", 64'(flush), 64'd0);
    chk("ex_cleared", 64'(exc == '0), 64'd1);
    chk("ex_resume", 64'(ack), 64'd3);
    tick();
    exp_ir = 64'd12;
    chk("ex_ir2", instret, exp_ir);

    ci[0] = mk(ALU, ADD, 5'd1, 64'h1, 1'b0, 64'd0);
    ci[1] = mk(CSR, CSRRW, 5'd2, 64'h2, 1'b0, 64'd0);
    #1;
    chk("csr_p1_ack", 64'(ack), 64'd1);
    tick();
    ci[0] = mk(CSR, CSRRW, 5'd2, 64'h2, 1'b0, 64'd0);
    ci[1] = mk(ALU, ADD, 5'd3, 64'h3, 1'b0, 64'd0);
    #1;
    chk("csr_p0_ack", 64'(ack), 64'd3);
    tick();
    exp_ir = 64'd15;
    chk("csr_ir", instret, exp_ir);

    ci[0] = mk(ALU, ADD, 5'd4, 64'h4, 1'b0, 64'd0);
    ci[1] = mk(ALU, ADD, 5'd5, 64'h5, 1'b0, 64'd0);
    halt_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("halt_ack", 64'(ack), 64'd0);
      tick();
    end
    halt_i = 1'b0;
    #1;
    chk("halt_drop_ack", 64'(ack), 64'd0);
    chk("halt_ir", instret, exp_ir);
    tick();
    chk("halt_resume", 64'(ack), 64'd3);
    tick();
    exp_ir = 64'd17;
    chk("halt_ir2", instret, exp_ir);

    ci[0] = mk(STORE, SD, 5'd0, 64'h0, 1'b0, 64'd0);
    ci[1] = '0;
    lsu_rdy = 1'b0;
    tick();
    chk("rsw_lsu", 64'(lsu), 64'd1);
    chk("rsw_ack", 64'(ack), 64'd0);
    rst_i = 1'b1;
    ci[0] = mk(ALU, ADD, 5'd12, 64'hC, 1'b0, 64'd0);
    #1;
    chk("rsw_rst_lsu", 64'(lsu), 64'd0);
    chk("rsw_rst_ack", 64'(ack), 64'd0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rsw_lsu_after", 64'(lsu), 64'd0);
    chk("rsw_ir_after", instret, 64'd0);
    chk("rsw_run_ack", 64'(ack), 64'd1);
    chk("rsw_flush", 64'(flush), 64'd0);
    tick();
    chk("rsw_ir_inc", instret, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
